// File: rtl/alg_cmd_pkg.sv
// Shared types and command packing for the algorithm frame-ring MM2S command generator.
package alg_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    LINE_DONE  = 2'd2,
    FRAME_DONE = 2'd3
  } state_e;

  localparam int CMD_W = 72;
  localparam int BTT_W = 23;

  // DataMover command: reserved, address, DRR=0, EOF=1, DSA=0, INCR=1, BTT
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [31:0] addr,
                                                input logic [BTT_W-1:0] btt);
    return {8'd0, addr, 1'b0, 1'b1, 6'd0, 1'b1, btt};
  endfunction

endpackage

// File: rtl/alg_edge_detect.sv
// Registered rising-edge detector producing a one-cycle pulse.
module alg_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_d_r;
  logic pulse_r;

  // Delay the input and flag a low-to-high transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_d_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sig_d_r <= sig;
      pulse_r <= sig & ~sig_d_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/alg_frame_cmd_gen.sv
// Issues one MM2S line-read command per channel, round-robin, for every line of
// the oldest NUM_CH-frame window in the frame ring, then slides the window.
module alg_frame_cmd_gen
  import alg_cmd_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int NUM_SLOT    = 4,
  parameter int IMG_STRIDE  = 1024*1025,
  parameter int LINE_STRIDE = 1024,
  parameter int LINE_BYTES  = 1024,
  parameter int NUM_LINE    = 1024,
  parameter int CACHE_WIDTH = 29
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      base_addr,
  input  logic                             load_addr,
  input  logic                             frame_store,
  input  logic [1:0]                       frame_type,
  output logic [NUM_CH*CMD_W-1:0]          m_axis_mm2s_cmd_tdata,
  output logic [NUM_CH-1:0]                m_axis_mm2s_cmd_tvalid,
  input  logic [NUM_CH-1:0]                m_axis_mm2s_cmd_tready,
  output logic [1:0]                       frame_type_o,
  output logic [$clog2(NUM_SLOT+1)-1:0]    frames_avail,
  output logic                             busy,
  output logic                             lost_read,
  output logic                             overflow
);

  localparam int SLOT_W  = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
  localparam int AVAIL_W = $clog2(NUM_SLOT+1);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LINE_W  = (NUM_LINE > 1) ? $clog2(NUM_LINE) : 1;
  localparam logic [31:0] LOW_MASK = (CACHE_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                     ((32'd1 << CACHE_WIDTH) - 32'd1);
  localparam logic [BTT_W-1:0]   BTT        = BTT_W'(LINE_BYTES);
  localparam logic [AVAIL_W-1:0] AVAIL_FULL = AVAIL_W'(NUM_SLOT);
  localparam logic [AVAIL_W-1:0] AVAIL_CH   = AVAIL_W'(NUM_CH);
  localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(NUM_LINE - 1);

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    if (s == SLOT_W'(NUM_SLOT - 1)) return {SLOT_W{1'b0}};
    else                            return s + SLOT_W'(1);
  endfunction

  function automatic logic [31:0] slot_offset(input logic [SLOT_W-1:0] rd, input int c);
    logic [31:0] idx;
    idx = (32'(rd) + 32'(c)) % 32'(NUM_SLOT);
    return idx * 32'(IMG_STRIDE);
  endfunction

  logic                load_pulse_s, store_pulse_s;
  logic                bg_store_s, load_apply_s, start_s, retire_s;
  logic [1:0]          ftype_smp_r, frame_type_r;
  logic [31:0]         base_addr_r, base_hi_r;
  logic                load_pend_r;
  logic [SLOT_W-1:0]   wr_slot_r, rd_slot_r, wr_base_s, wr_slot_nx_s, rd_slot_nx_s;
  logic [AVAIL_W-1:0]  avail_r, avail_base_s, avail_nx_s;
  logic                overflow_r, lost_read_r, clr_seen_r;
  logic                overflow_nx_s, lost_read_nx_s, clr_seen_nx_s;
  state_e              state_r;
  logic [CH_W-1:0]     ch_r;
  logic [LINE_W-1:0]   line_cnt_r;
  logic [31:0]         addr_r [NUM_CH];

  alg_edge_detect u_load_edge (.clk(clk), .rst(rst), .sig(load_addr),   .pulse(load_pulse_s));
  alg_edge_detect u_store_edge(.clk(clk), .rst(rst), .sig(frame_store), .pulse(store_pulse_s));

  assign bg_store_s   = store_pulse_s && (ftype_smp_r == 2'b00);
  assign load_apply_s = load_pend_r && (state_r == IDLE);
  assign start_s      = (state_r == IDLE) && !load_pend_r && (avail_r >= AVAIL_CH);
  assign retire_s     = (state_r == FRAME_DONE) && !clr_seen_r;

  // Next ring pointers, frame count and sticky flags; background store wins over retirement
  always_comb begin
    wr_base_s      = load_apply_s ? {SLOT_W{1'b0}} : wr_slot_r;
    rd_slot_nx_s   = rd_slot_r;
    avail_base_s   = avail_r;
    if (load_apply_s) begin
      rd_slot_nx_s = {SLOT_W{1'b0}};
      avail_base_s = {AVAIL_W{1'b0}};
    end else if (retire_s) begin
      rd_slot_nx_s = slot_inc(rd_slot_r);
      avail_base_s = avail_r - AVAIL_W'(1);
    end else begin
      rd_slot_nx_s = rd_slot_r;
      avail_base_s = avail_r;
    end
    wr_slot_nx_s   = wr_base_s;
    avail_nx_s     = avail_base_s;
    overflow_nx_s  = overflow_r;
    lost_read_nx_s = lost_read_r;
    if (store_pulse_s) begin
      wr_slot_nx_s = slot_inc(wr_base_s);
      if (bg_store_s) begin
        rd_slot_nx_s   = wr_base_s;
        avail_nx_s     = AVAIL_W'(1);
        lost_read_nx_s = lost_read_r || (state_r != IDLE) || (avail_r >= AVAIL_CH);
      end else begin
        avail_nx_s    = (avail_base_s == AVAIL_FULL) ? avail_base_s : avail_base_s + AVAIL_W'(1);
        overflow_nx_s = overflow_r || (avail_base_s == AVAIL_FULL);
      end
    end else begin
      wr_slot_nx_s = wr_base_s;
    end
    if (state_r == FRAME_DONE) begin
      clr_seen_nx_s = 1'b0;
    end else if (bg_store_s && ((state_r != IDLE) || start_s)) begin
      clr_seen_nx_s = 1'b1;
    end else begin
      clr_seen_nx_s = clr_seen_r;
    end
  end

  // Ring bookkeeping registers, base capture and pending-load tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_slot_r    <= {SLOT_W{1'b0}};
      rd_slot_r    <= {SLOT_W{1'b0}};
      avail_r      <= {AVAIL_W{1'b0}};
      overflow_r   <= 1'b0;
      lost_read_r  <= 1'b0;
      clr_seen_r   <= 1'b0;
      load_pend_r  <= 1'b0;
      base_addr_r  <= 32'd0;
      ftype_smp_r  <= 2'b00;
      frame_type_r <= 2'b00;
    end else begin
      wr_slot_r   <= wr_slot_nx_s;
      rd_slot_r   <= rd_slot_nx_s;
      avail_r     <= avail_nx_s;
      overflow_r  <= overflow_nx_s;
      lost_read_r <= lost_read_nx_s;
      clr_seen_r  <= clr_seen_nx_s;
      ftype_smp_r <= frame_type;
      if (load_pulse_s) begin
        load_pend_r <= 1'b1;
        base_addr_r <= base_addr;
      end else if (load_apply_s) begin
        load_pend_r <= 1'b0;
      end
      if (store_pulse_s) frame_type_r <= ftype_smp_r;
    end
  end

  // Command sequencer: window latch, per-channel issue, line and frame stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ch_r       <= {CH_W{1'b0}};
      line_cnt_r <= {LINE_W{1'b0}};
      base_hi_r  <= 32'd0;
      for (int c = 0; c < NUM_CH; c++) addr_r[c] <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r   <= ISSUE;
            ch_r      <= {CH_W{1'b0}};
            base_hi_r <= base_addr_r & ~LOW_MASK;
            for (int c = 0; c < NUM_CH; c++) addr_r[c] <= base_addr_r + slot_offset(rd_slot_r, c);
          end
        end
        ISSUE: begin
          if (m_axis_mm2s_cmd_tready[ch_r]) begin
            if (ch_r == CH_LAST) state_r <= LINE_DONE;
            else                 ch_r    <= ch_r + CH_W'(1);
          end
        end
        LINE_DONE: begin
          for (int c = 0; c < NUM_CH; c++) addr_r[c] <= addr_r[c] + 32'(LINE_STRIDE);
          line_cnt_r <= line_cnt_r + LINE_W'(1);
          if (line_cnt_r == LINE_LAST) begin
            state_r <= FRAME_DONE;
          end else begin
            state_r <= ISSUE;
            ch_r    <= {CH_W{1'b0}};
          end
        end
        FRAME_DONE: begin
          line_cnt_r <= {LINE_W{1'b0}};
          state_r    <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign m_axis_mm2s_cmd_tvalid[c] = (state_r == ISSUE) && (ch_r == CH_W'(c));
    assign m_axis_mm2s_cmd_tdata[c*CMD_W +: CMD_W] =
      pack_cmd(base_hi_r | (addr_r[c] & LOW_MASK), BTT);
  end

  assign frame_type_o = frame_type_r;
  assign frames_avail = avail_r;
  assign busy         = (state_r != IDLE);
  assign lost_read    = lost_read_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_alg_frame_cmd_gen.sv
// Directed, table-driven bench for alg_frame_cmd_gen with a 2-channel, 4-slot, 4-line ring.
module tb_alg_frame_cmd_gen;

  localparam int NUM_CH      = 2;
  localparam int NUM_SLOT    = 4;
  localparam int NUM_LINE    = 4;
  localparam int IMG_STRIDE  = 1024*1025;
  localparam int LINE_STRIDE = 1024;
  localparam logic [31:0] BASE_A = 32'h1000_0000;
  localparam logic [31:0] BASE_B = 32'hE800_0000;

  logic                   clk;
  logic                   rst;
  logic [31:0]            base_addr;
  logic                   load_addr;
  logic                   frame_store;
  logic [1:0]             frame_type;
  logic [NUM_CH*72-1:0]   tdata;
  logic [NUM_CH-1:0]      tvalid;
  logic [NUM_CH-1:0]      tready;
  logic [1:0]             frame_type_o;
  logic [2:0]             frames_avail;
  logic                   busy;
  logic                   lost_read;
  logic                   overflow;

  alg_frame_cmd_gen #(
    .NUM_CH(NUM_CH), .NUM_SLOT(NUM_SLOT), .IMG_STRIDE(IMG_STRIDE),
    .LINE_STRIDE(LINE_STRIDE), .LINE_BYTES(1024), .NUM_LINE(NUM_LINE), .CACHE_WIDTH(29)
  ) dut (
    .clk(clk), .rst(rst), .base_addr(base_addr), .load_addr(load_addr),
    .frame_store(frame_store), .frame_type(frame_type),
    .m_axis_mm2s_cmd_tdata(tdata), .m_axis_mm2s_cmd_tvalid(tvalid),
    .m_axis_mm2s_cmd_tready(tready), .frame_type_o(frame_type_o),
    .frames_avail(frames_avail), .busy(busy), .lost_read(lost_read), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [1:0] ftype;
    logic       win;
    int         slot0;
    int         exp_avail;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] exp_cmd(input logic [31:0] base, input int slot, input int line);
    logic [31:0] raw;
    logic [31:0] addr;
    raw  = base + 32'(slot) * 32'(IMG_STRIDE) + 32'(line) * 32'(LINE_STRIDE);
    addr = {base[31:29], raw[28:0]};
    return {8'h00, addr, 1'b0, 1'b1, 6'b000000, 1'b1, 23'd1024};
  endfunction

  task automatic do_store(input logic [1:0] ft);
    frame_type  = ft;
    frame_store = 1'b1;
    step();
    frame_store = 1'b0;
    step();
  endtask

  task automatic do_load(input logic [31:0] base);
    base_addr = base;
    load_addr = 1'b1;
    step();
    load_addr = 1'b0;
    repeat (4) step();
  endtask

  task automatic store_and_check(input logic [1:0] ft, input logic win, input int exp_avail);
    do_store(ft);
    check("avail_after_store", 72'(frames_avail), 72'(exp_avail));
    check("frame_type_o", 72'(frame_type_o), 72'(ft));
    check("tvalid_before_start", 72'(tvalid), 72'(0));
    step();
    check("tvalid_at_start", 72'(tvalid), win ? 72'(1) : 72'(0));
  endtask

  // ev_kind 1 = background store, 2 = load of BASE_B, injected at command index ev_at
  task automatic run_frame(input int slot0, input logic [31:0] base, input int start_idx,
                           input int ev_at, input int ev_kind);
    int n;
    for (int idx = start_idx; idx < NUM_LINE*NUM_CH; idx++) begin
      int ch;
      int line;
      ch   = idx % NUM_CH;
      line = idx / NUM_CH;
      n    = 0;
      while (tvalid[ch] !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      check("cmd_gap", 72'(n), (ch == 0 && idx != start_idx) ? 72'(1) : 72'(0));
      check("cmd_valid", 72'(tvalid), 72'(1 << ch));
      check("cmd_data", tdata[ch*72 +: 72], exp_cmd(base, (slot0 + ch) % NUM_SLOT, line));
      if (idx == ev_at) begin
        if (ev_kind == 1) begin
          frame_type  = 2'b00;
          frame_store = 1'b1;
        end else begin
          base_addr = BASE_B;
          load_addr = 1'b1;
        end
      end
      step();
      frame_store = 1'b0;
      load_addr   = 1'b0;
    end
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("frame_tail", 72'(n), 72'(2));
  endtask

  initial begin
    vecs[0] = '{ftype: 2'b01, win: 1'b0, slot0: 0, exp_avail: 1};
    vecs[1] = '{ftype: 2'b01, win: 1'b1, slot0: 0, exp_avail: 2};
    vecs[2] = '{ftype: 2'b01, win: 1'b1, slot0: 1, exp_avail: 2};
    vecs[3] = '{ftype: 2'b10, win: 1'b1, slot0: 2, exp_avail: 2};
    vecs[4] = '{ftype: 2'b11, win: 1'b1, slot0: 3, exp_avail: 2};
    vecs[5] = '{ftype: 2'b01, win: 1'b1, slot0: 0, exp_avail: 2};

    rst = 1'b1; base_addr = 32'd0; load_addr = 1'b0; frame_store = 1'b0;
    frame_type = 2'b00; tready = 2'b11;
    repeat (2) step();
    check("rst_tvalid", 72'(tvalid), 72'(0));
    check("rst_avail", 72'(frames_avail), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_flags", 72'({lost_read, overflow}), 72'(0));
    check("rst_ftype", 72'(frame_type_o), 72'(0));
    rst = 1'b0;
    step();
    do_load(BASE_A);

    // Basic window, sliding and read-pointer wrap
    for (int i = 0; i < 6; i++) begin
      store_and_check(vecs[i].ftype, vecs[i].win, vecs[i].exp_avail);
      if (vecs[i].win) begin
        run_frame(vecs[i].slot0, BASE_A, 0, -1, 0);
        check("avail_after_frame", 72'(frames_avail), 72'(1));
      end
    end
    check("no_flags_yet", 72'({lost_read, overflow}), 72'(0));

    // Backpressure on channel 1
    tready = 2'b01;
    store_and_check(2'b01, 1'b1, 2);
    check("bp_ch0_data", tdata[71:0], exp_cmd(BASE_A, 1, 0));
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 72'(tvalid), 72'(2'b10));
      check("bp_hold_data", tdata[143:72], exp_cmd(BASE_A, 2, 0));
      step();
    end
    tready = 2'b11;
    run_frame(1, BASE_A, 1, -1, 0);
    check("bp_avail", 72'(frames_avail), 72'(1));

    // Background store in the middle of a frame
    store_and_check(2'b01, 1'b1, 2);
    run_frame(2, BASE_A, 0, 3, 1);
    check("bg_lost_read", 72'(lost_read), 72'(1));
    check("bg_avail", 72'(frames_avail), 72'(1));
    check("bg_ftype", 72'(frame_type_o), 72'(2'b00));
    store_and_check(2'b10, 1'b1, 2);
    run_frame(0, BASE_A, 0, -1, 0);
    check("bg_next_avail", 72'(frames_avail), 72'(1));

    // Overflow with the command ports stalled
    tready = 2'b00;
    do_load(BASE_A);
    check("load_idle_clear", 72'(frames_avail), 72'(0));
    for (int s = 1; s <= 5; s++) begin
      do_store(2'b01);
      check("ovf_avail", 72'(frames_avail), 72'((s > 4) ? 4 : s));
      check("ovf_flag", 72'(overflow), 72'(s == 5));
    end
    check("ovf_stuck_valid", 72'(tvalid), 72'(2'b01));
    check("ovf_stuck_data", tdata[71:0], exp_cmd(BASE_A, 0, 0));

    // Asynchronous reset while issuing
    #3 rst = 1'b1;
    #1;
    check("arst_tvalid", 72'(tvalid), 72'(0));
    check("arst_avail", 72'(frames_avail), 72'(0));
    check("arst_busy", 72'(busy), 72'(0));
    check("arst_flags", 72'({lost_read, overflow}), 72'(0));
    #2 rst = 1'b0;
    step();

    // Load arriving while busy is held until the frame retires
    tready = 2'b11;
    do_load(BASE_A);
    store_and_check(2'b01, 1'b0, 1);
    store_and_check(2'b01, 1'b1, 2);
    run_frame(0, BASE_A, 0, 2, 2);
    check("pend_not_applied", 72'(frames_avail), 72'(1));
    step();
    step();
    check("pend_applied", 72'(frames_avail), 72'(0));
    store_and_check(2'b01, 1'b0, 1);
    store_and_check(2'b01, 1'b1, 2);
    run_frame(0, BASE_B, 0, -1, 0);
    check("pend_final_avail", 72'(frames_avail), 72'(1));

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
